mesm6_prefetch: RTL and testbench
=================================

# mesm6_prefetch

Parametrised instruction prefetch unit for the MESM-6 core. It replaces the single-word opcode cache with a DEPTH-word queue that fetches sequential instruction words ahead of execution. It hands the core one 24-bit half-word opcode at a time, left half first. It sits between the core sequencer and the instruction memory bus, which keeps the existing `ibus_*` protocol.

## Interface
- `DEPTH`, 4: queue depth in 48-bit words; power of two, ≥2.
- `AW`, 15: word address width.
- `DW`, 48: instruction word width; even.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `redirect` in 1: flush the queue and restart at `redirect_pc`.
- `redirect_pc` in AW+1: half-word address; bit 0 set selects the right half.
- `op_valid` out 1: `opcode` and `op_pc` are valid.
- `opcode` out DW/2: current half-word instruction.
- `op_pc` out AW+1: half-word address of `opcode`.
- `op_ack` in 1: core consumes `opcode`; ignored unless `op_valid`.
- `ibus_fetch` out 1: fetch request, registered.
- `ibus_addr` out AW: fetch word address, registered.
- `ibus_input` in DW: fetched word.
- `ibus_done` in 1: fetch completes in this cycle.
- `count` out $clog2(DEPTH)+1: words held in the queue.

## Operation
- Queue entries hold {word, word address}. The head half pointer `half` selects the output: `opcode` = `half` ? head[DW/2-1:0] : head[DW-1:DW/2].
- `op_pc` = {head address, `half`}. `op_valid` = (`count` != 0).
- Consume (`op_ack` & `op_valid`):
  - `half`=0 → `half`<=1.
  - `half`=1 → pop the head and set `half`<=0.
- Enable flag `run`:
  - Cleared by reset; set by the first `redirect`.
  - No fetch is ever issued while `run`=0.
- Bus FSM states:
  - B_IDLE: no request.
  - B_REQ: request outstanding, data wanted.
  - B_STALE: request outstanding, data to be discarded.
- Transitions:
  - B_IDLE → B_REQ when `run` & (`count` + 0) < DEPTH & no redirect this cycle. `ibus_addr`<=`fetch_addr` and `ibus_fetch`<=1.
  - B_REQ & `ibus_done` → push {`ibus_input`, `ibus_addr`}, `fetch_addr`<=`fetch_addr`+1, then go to B_IDLE. If `count`+1 < DEPTH and no pop is needed to make room, the next request is issued in the same edge (back-to-back).
  - B_REQ & `redirect` & ~`ibus_done` → B_STALE; `ibus_fetch` stays high (bus requests cannot be withdrawn).
  - B_STALE & `ibus_done` → discard the data, drop `ibus_fetch`, go to B_IDLE.
- Issue rule: a request is issued only when `count` < DEPTH after this cycle's pop/push. A completion can therefore never overflow the queue.
- Redirect:
  - Empties the queue (`count`<=0), sets `half`<=`redirect_pc[0]` and `fetch_addr`<=`redirect_pc[AW:1]`.
  - Overrides `op_ack` and any push in the same cycle.
  - `redirect` together with `ibus_done` in B_REQ discards the data and goes to B_IDLE.
- `fetch_addr` wraps from 2^AW−1 to 0. Queue pointers wrap modulo DEPTH.
- Push and pop in the same cycle are both performed; `count` is unchanged.

## Timing
- Reset values, all zero: `ibus_fetch`, `ibus_addr`, `op_valid`, `opcode`, `op_pc`, `count`, `half`, `run`, `fetch_addr`, bus state B_IDLE.
- Redirect at edge t (no stale request) → `ibus_fetch`=1 after edge t+1. With `ibus_done` in that cycle, `op_valid`=1 after edge t+2.
- Redirect with a stale request outstanding → the new fetch is issued on the edge after the stale `ibus_done`.
- Steady state with a 1-cycle bus: one word per cycle until full; the core sees no bubble at half-word rate.
- `ibus_fetch`/`ibus_addr` stay stable from issue until `ibus_done`.
- Asserting `reset_n`=0 mid-request immediately clears `ibus_fetch`. The memory is assumed reset together with the core.

## Structure
- Shared package `mesm6_pkg`: bus FSM enum (B_IDLE/B_REQ/B_STALE) and half-select constants (HALF_LEFT=0, HALF_RIGHT=1). Widths are derived from parameters locally.
- One sub-module: `mesm6_fifo_tagged`, a DEPTH×(DW+AW) register FIFO with push/pop/flush and count, using the same asynchronous active-low reset.
- The top level holds the bus FSM, `run`, `half` and `fetch_addr`.

## Test plan
- Reset, then idle 10 cycles with no redirect → `ibus_fetch` stays 0 and `op_valid` stays 0.
- `redirect_pc`=0x0200 with a 1-cycle bus, memory[0x100]=0x123456_ABCDEF:
  - `opcode`=0x123456 with `op_pc`=0x0200, then after `op_ack` `opcode`=0xABCDEF with `op_pc`=0x0201.
  - Fetches 0x100..0x103 issue back-to-back, and `count` reaches 4 with no fifth fetch.
- `redirect_pc`=0x0051 → first `opcode` is the right half of word 0x28 with `op_pc`=0x0051, and the next acked op comes from word 0x29.
- Redirect to 0x0400 while a fetch of 0x105 waits (3-cycle bus):
  - The 0x105 data is discarded and never appears on `opcode`.
  - The next `ibus_addr` is 0x200, issued after the stale done.
- `redirect_pc`=0xFFFE → fetches 0x7FFF then 0x0000; `op_pc` goes 0xFFFE, 0xFFFF, 0x0000.
- Full queue: `op_ack` on a right half together with `ibus_done` disallowed → verify no issue when full. A pop in the same cycle as a new issue gives `count` 4→3→4 with no overflow. Asserting `reset_n` low mid-transfer gives all outputs 0 the same cycle.

Source files
------------

// File: rtl/mesm6_pkg.sv
// Shared MESM-6 definitions: bus FSM encoding and half-word select values.
package mesm6_pkg;

  typedef enum logic [1:0] {
    B_IDLE  = 2'd0,
    B_REQ   = 2'd1,
    B_STALE = 2'd2
  } bus_state_t;

  localparam logic HALF_LEFT  = 1'b0;
  localparam logic HALF_RIGHT = 1'b1;

endpackage

// File: rtl/mesm6_fifo_tagged.sv
// DEPTH-entry register FIFO of {word, word address} with push/pop/flush and occupancy count.
module mesm6_fifo_tagged #(
  parameter int DEPTH = 4,
  parameter int AW    = 15,
  parameter int DW    = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            push_data,
  input  logic [AW-1:0]            push_addr,
  output logic [DW-1:0]            head_data,
  output logic [AW-1:0]            head_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] addr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign head_data = data_mem[rd_ptr];
  assign head_addr = addr_mem[rd_ptr];

  // Storage is reset too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        addr_mem[wr_ptr] <= push_addr;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mesm6_prefetch.sv
// MESM-6 instruction prefetch: fetches sequential words ahead into a tagged FIFO
// and presents them to the core one 24-bit half-word at a time, left half first.
module mesm6_prefetch
  import mesm6_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 15,
  parameter int DW    = 48
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   redirect,
  input  logic [AW:0]            redirect_pc,
  output logic                   op_valid,
  output logic [DW/2-1:0]        opcode,
  output logic [AW:0]            op_pc,
  input  logic                   op_ack,
  output logic                   ibus_fetch,
  output logic [AW-1:0]          ibus_addr,
  input  logic [DW-1:0]          ibus_input,
  input  logic                   ibus_done,
  output logic [$clog2(DEPTH):0] count,
  output bus_state_t             bus_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Handshakes: an opcode transfers on a cycle with op_valid & op_ack (op_ack is
  // ignored otherwise); a bus request holds ibus_fetch/ibus_addr stable from issue
  // until the cycle with ibus_done, and is never withdrawn before that.

  bus_state_t    state_q, state_d;
  logic          run_q, run_d;
  logic          half_q, half_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] fetch_addr_inc;
  logic          ibus_fetch_d;
  logic [AW-1:0] ibus_addr_d;

  logic [DW-1:0] head_data;
  logic [AW-1:0] head_addr;
  logic          consume;
  logic          pop;
  logic          push;
  logic          req_done;
  logic          can_issue;
  logic [CW-1:0] count_next;

  mesm6_fifo_tagged #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (ibus_input),
    .push_addr (ibus_addr),
    .head_data (head_data),
    .head_addr (head_addr),
    .count     (count)
  );

  assign bus_state      = state_q;
  assign op_valid       = (count != '0);
  assign opcode         = (half_q == HALF_RIGHT) ? head_data[DW/2-1:0] : head_data[DW-1:DW/2];
  assign op_pc          = {head_addr, half_q};
  assign fetch_addr_inc = fetch_addr_q + 1'b1;

  // Redirect wins over both consumption and a completing fetch.
  assign consume  = op_ack & op_valid & ~redirect;
  assign pop      = consume & (half_q == HALF_RIGHT);
  assign req_done = (state_q == B_REQ) & ibus_done;
  assign push     = req_done & ~redirect;

  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  // A new request needs a free slot once this cycle's pop/push has settled.
  assign can_issue = run_q & ~redirect & (count_next < DEPTH_C);

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    half_d       = half_q;
    fetch_addr_d = fetch_addr_q;
    ibus_fetch_d = ibus_fetch;
    ibus_addr_d  = ibus_addr;

    if (consume) begin
      half_d = (half_q == HALF_RIGHT) ? HALF_LEFT : HALF_RIGHT;
    end
    if (redirect) begin
      run_d        = 1'b1;
      half_d       = redirect_pc[0];
      fetch_addr_d = redirect_pc[AW:1];
    end

    case (state_q)
      B_IDLE: begin
        if (can_issue) begin
          state_d      = B_REQ;
          ibus_fetch_d = 1'b1;
          ibus_addr_d  = fetch_addr_q;
        end
      end
      B_REQ: begin
        if (ibus_done) begin
          if (redirect) begin
            state_d      = B_IDLE;
            ibus_fetch_d = 1'b0;
          end else begin
            fetch_addr_d = fetch_addr_inc;
            if (can_issue) begin
              ibus_addr_d = fetch_addr_inc;
            end else begin
              state_d      = B_IDLE;
              ibus_fetch_d = 1'b0;
            end
          end
        end else if (redirect) begin
          state_d = B_STALE;
        end
      end
      B_STALE: begin
        if (ibus_done) begin
          state_d      = B_IDLE;
          ibus_fetch_d = 1'b0;
        end
      end
      default: begin
        state_d      = B_IDLE;
        ibus_fetch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= B_IDLE;
      run_q        <= 1'b0;
      half_q       <= HALF_LEFT;
      fetch_addr_q <= '0;
      ibus_fetch   <= 1'b0;
      ibus_addr    <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      half_q       <= half_d;
      fetch_addr_q <= fetch_addr_d;
      ibus_fetch   <= ibus_fetch_d;
      ibus_addr    <= ibus_addr_d;
    end
  end

endmodule

// File: tb/tb_mesm6_prefetch.sv
// Directed bench for mesm6_prefetch: memory model with variable latency, opcode scoreboard.
module tb_mesm6_prefetch;
  import mesm6_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 15;
  localparam int DW    = 48;
  localparam int OW    = DW / 2 + AW + 1;

  logic                   clk = 1'b0;
  logic                   reset_n = 1'b0;
  logic                   redirect = 1'b0;
  logic [AW:0]            redirect_pc = '0;
  logic                   op_valid;
  logic [DW/2-1:0]        opcode;
  logic [AW:0]            op_pc;
  logic                   op_ack = 1'b0;
  logic                   ibus_fetch;
  logic [AW-1:0]          ibus_addr;
  logic [DW-1:0]          ibus_input = '0;
  logic                   ibus_done = 1'b0;
  logic [$clog2(DEPTH):0] count;
  bus_state_t             bus_state;

  int tests = 0;
  int fails = 0;
  int lat   = 1;
  logic [OW-1:0] exp_q[$];
  logic [AW-1:0] done_log[$];

  mesm6_prefetch #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .op_valid    (op_valid),
    .opcode      (opcode),
    .op_pc       (op_pc),
    .op_ack      (op_ack),
    .ibus_fetch  (ibus_fetch),
    .ibus_addr   (ibus_addr),
    .ibus_input  (ibus_input),
    .ibus_done   (ibus_done),
    .count       (count),
    .bus_state   (bus_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- memory contents ----------------
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    if (a == 15'h100) return 48'h123456_ABCDEF;
    return {9'h1AB, a, 9'h0CD, a};
  endfunction

  function automatic logic [OW-1:0] exp_op(input logic [AW:0] hp);
    logic [DW-1:0] w;
    w = mem_word(hp[AW:1]);
    return {(hp[0] ? w[DW/2-1:0] : w[DW-1:DW/2]), hp};
  endfunction

  // ---------------- bus responder: done after `lat` cycles of a request ----------------
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || !ibus_fetch) begin
        ibus_done = 1'b0;
        wait_cnt  = 0;
      end else begin
        if (ibus_done) wait_cnt = 0;
        wait_cnt++;
        ibus_done  = (wait_cnt >= lat);
        ibus_input = mem_word(ibus_addr);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [OW-1:0] e;
    if (reset_n && ibus_fetch && ibus_done) done_log.push_back(ibus_addr);
    if (reset_n && op_valid && op_ack && !redirect) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL op_unexpected: got opcode %h pc %h, required none", opcode, op_pc);
      end else begin
        e = exp_q.pop_front();
        if ({opcode, op_pc} !== e) begin
          fails++;
          $display("FAIL op_stream: got opcode %h pc %h, required opcode %h pc %h",
                   opcode, op_pc, e[OW-1:AW+1], e[AW:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [AW:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  task automatic push_exp(input logic [AW:0] start, input int n);
    logic [AW:0] hp;
    hp = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_op(hp));
      hp = hp + 1'b1;
    end
  endtask

  task automatic ack_ops(input int n);
    int got, guard;
    got   = 0;
    guard = 0;
    while (got < n && guard < 200) begin
      op_ack = op_valid;
      @(posedge clk);
      if (op_ack) got++;
      #1;
      guard++;
    end
    op_ack = 1'b0;
    check("ack_ops_done", 64'(got), 64'(n));
  endtask

  task automatic wait_count(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (count != target && n < budget) begin
      tick(1);
      n++;
    end
    check(name, 64'(count), 64'(target));
  endtask

  task automatic quiesce(input string name);
    int n;
    n = 0;
    while (ibus_fetch && n < 60) begin
      tick(1);
      n++;
    end
    check(name, 64'(ibus_fetch), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic any;

    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check("rst_fetch", 64'(ibus_fetch), 64'd0);
    check("rst_addr", 64'(ibus_addr), 64'd0);
    check("rst_valid", 64'(op_valid), 64'd0);
    check("rst_opcode", 64'(opcode), 64'd0);
    check("rst_pc", 64'(op_pc), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_state", 64'(bus_state), 64'(B_IDLE));

    any = 1'b0;
    repeat (10) begin
      tick(1);
      if (ibus_fetch || op_valid) any = 1'b1;
    end
    check("idle_no_fetch", 64'(any), 64'd0);

    // Sequential fill from 0x0200 with a 1-cycle bus
    lat = 1;
    done_log.delete();
    do_redirect(16'h0200);
    check("redir_no_fetch_yet", 64'(ibus_fetch), 64'd0);
    tick(1);
    check("first_fetch", 64'(ibus_fetch), 64'd1);
    check("first_addr", 64'(ibus_addr), 64'h100);
    tick(1);
    check("first_valid", 64'(op_valid), 64'd1);
    check("first_opcode", 64'(opcode), 64'h123456);
    check("first_pc", 64'(op_pc), 64'h0200);
    wait_count(4, 20, "fill_count");
    tick(5);
    check("full_no_fifth", 64'(ibus_fetch), 64'd0);
    check("full_count", 64'(count), 64'd4);
    check("fill_fetches", 64'(done_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < done_log.size(); i++)
      check("fill_addr", 64'(done_log[i]), 64'(15'h100 + i));
    push_exp(16'h0200, 2);
    ack_ops(2);

    // Start on a right half
    quiesce("quiesce_a");
    done_log.delete();
    do_redirect(16'h0051);
    push_exp(16'h0051, 3);
    ack_ops(3);
    check("right_start_word", 64'(done_log.size() > 0 ? done_log[0] : 15'h7ABC), 64'h28);

    // Redirect while the fetch of 0x105 is outstanding on a 3-cycle bus
    quiesce("quiesce_b");
    lat = 3;
    do_redirect(16'h0208);
    n = 0;
    while (!(ibus_fetch && ibus_addr == 15'h105) && n < 40) begin
      tick(1);
      n++;
    end
    check("stale_setup", 64'(ibus_addr), 64'h105);
    do_redirect(16'h0400);
    check("stale_state", 64'(bus_state), 64'(B_STALE));
    check("stale_hold_fetch", 64'(ibus_fetch), 64'd1);
    check("stale_hold_addr", 64'(ibus_addr), 64'h105);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(ibus_done && ibus_addr == 15'h105) && n < 10);
    check("stale_done_seen", 64'(ibus_done), 64'd1);
    @(posedge clk);
    #2;
    check("stale_drop", 64'(ibus_fetch), 64'd0);
    @(posedge clk);
    #2;
    check("after_stale_fetch", 64'(ibus_fetch), 64'd1);
    check("after_stale_addr", 64'(ibus_addr), 64'h200);
    push_exp(16'h0400, 4);
    ack_ops(4);

    // Address wrap
    quiesce("quiesce_c");
    lat = 1;
    done_log.delete();
    do_redirect(16'hFFFE);
    push_exp(16'hFFFE, 3);
    ack_ops(3);
    check("wrap_fetch0", 64'(done_log.size() > 0 ? done_log[0] : 15'h1234), 64'h7FFF);
    check("wrap_fetch1", 64'(done_log.size() > 1 ? done_log[1] : 15'h1234), 64'h0000);

    // Full queue: pop frees exactly one slot, refilled with no overflow
    quiesce("quiesce_d");
    do_redirect(16'h0300);
    wait_count(4, 20, "full2_count");
    tick(3);
    check("full2_no_issue", 64'(ibus_fetch), 64'd0);
    push_exp(16'h0300, 2);
    op_ack = 1'b1;
    tick(1);
    op_ack = 1'b0;
    check("left_ack_count", 64'(count), 64'd4);
    check("left_ack_pc", 64'(op_pc), 64'h0301);
    check("left_ack_no_issue", 64'(ibus_fetch), 64'd0);
    op_ack = 1'b1;
    tick(1);
    op_ack = 1'b0;
    check("pop_count", 64'(count), 64'd3);
    check("pop_issue", 64'(ibus_fetch), 64'd1);
    check("pop_issue_addr", 64'(ibus_addr), 64'h184);
    tick(1);
    check("refill_count", 64'(count), 64'd4);
    check("refill_no_issue", 64'(ibus_fetch), 64'd0);

    // Asynchronous reset in the middle of a transfer
    quiesce("quiesce_e");
    lat = 3;
    do_redirect(16'h0004);
    n = 0;
    while (!(count >= 1 && ibus_fetch) && n < 40) begin
      tick(1);
      n++;
    end
    check("midreset_setup", 64'(ibus_fetch), 64'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("midreset_fetch", 64'(ibus_fetch), 64'd0);
    check("midreset_addr", 64'(ibus_addr), 64'd0);
    check("midreset_valid", 64'(op_valid), 64'd0);
    check("midreset_opcode", 64'(opcode), 64'd0);
    check("midreset_pc", 64'(op_pc), 64'd0);
    check("midreset_count", 64'(count), 64'd0);
    check("midreset_state", 64'(bus_state), 64'(B_IDLE));
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("post_reset_idle", 64'(ibus_fetch), 64'd0);

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
